// File: rtl/sparse_index_sched_pkg.sv
// rtl/sparse_index_sched_pkg.sv - shared types and helpers for the sparse index scheduler
package sparse_pkg;

   localparam int SP_DATA_WIDTH  = 16;
   localparam int SP_INDEX_WIDTH = 4;

   // Bitmap and index types shared with the PE address generator
   typedef logic [SP_DATA_WIDTH-1:0]  sp_bmp_t;
   typedef logic [SP_INDEX_WIDTH-1:0] sp_idx_t;
   typedef logic [SP_INDEX_WIDTH:0]   sp_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } sp_state_t;

   // Ceiling log2, used at elaboration to validate index width against bitmap width
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sparse_index_sched_if.sv
// rtl/sparse_index_sched_if.sv - bitmap-in / index-out handshake bundle
interface sparse_index_sched_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int INDEX_WIDTH = 4
);
   logic                   flush;
   logic                   and_mode;
   logic                   bmp_valid;
   logic                   bmp_ready;
   logic [DATA_WIDTH-1:0]  act_bmp;
   logic [DATA_WIDTH-1:0]  wei_bmp;
   logic                   idx_valid;
   logic                   idx_ready;
   logic [INDEX_WIDTH-1:0] idx;
   logic                   idx_last;
   logic                   row_done;
   logic [INDEX_WIDTH:0]   row_nnz;

   // Row controller / consumer side
   modport master (
      output flush, and_mode, bmp_valid, act_bmp, wei_bmp, idx_ready,
      input  bmp_ready, idx_valid, idx, idx_last, row_done, row_nnz
   );

   // Scheduler side
   modport slave (
      input  flush, and_mode, bmp_valid, act_bmp, wei_bmp, idx_ready,
      output bmp_ready, idx_valid, idx, idx_last, row_done, row_nnz
   );
endinterface

// File: rtl/sparse_index_sched_lowest_one_enc.sv
// rtl/sparse_index_sched_lowest_one_enc.sv - lowest-set-bit encoder with single-bit flag
module lowest_one_enc #(
   parameter int DATA_WIDTH  = 16,
   parameter int INDEX_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0]  vec,
   output logic [INDEX_WIDTH-1:0] idx,
   output logic                   one_hot
);

   logic [DATA_WIDTH-1:0] iso;

   // Isolate lowest one (vec & -vec) and OR-encode its position; flag exactly one set bit
   always_comb begin
      iso     = vec & (~vec + {{(DATA_WIDTH-1){1'b0}}, 1'b1});
      idx     = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (iso[i]) begin
            idx = idx | INDEX_WIDTH'(i);
         end
      end
      one_hot = (vec != '0) && ((vec & (vec - {{(DATA_WIDTH-1){1'b0}}, 1'b1})) == '0);
   end

endmodule

// File: rtl/sparse_index_sched.sv
// rtl/sparse_index_sched.sv - walks a sparsity bitmap row and emits nonzero positions
module sparse_index_sched
   import sparse_pkg::*;
#(
   parameter int DATA_WIDTH  = SP_DATA_WIDTH,
   parameter int INDEX_WIDTH = SP_INDEX_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   sparse_index_sched_if.slave bus
);

   if (INDEX_WIDTH < clog2(DATA_WIDTH)) begin : g_bad_width
      $error("INDEX_WIDTH too small for DATA_WIDTH");
   end

   sp_state_t              state_q, state_d;
   logic [DATA_WIDTH-1:0]  rem_q, rem_d;
   logic [INDEX_WIDTH:0]   nnz_q, nnz_d;

   logic                   bmp_ready_q, bmp_ready_d;
   logic                   idx_valid_q, idx_valid_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic                   idx_last_q, idx_last_d;
   logic                   row_done_q, row_done_d;
   logic [INDEX_WIDTH:0]   row_nnz_q, row_nnz_d;

   logic [DATA_WIDTH-1:0]  load_bmp;
   logic [INDEX_WIDTH-1:0] enc_idx;
   logic                   enc_one_hot;

   // Encoder looks at the next remainder so idx/idx_last can be registered
   lowest_one_enc #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_enc (
      .vec     (rem_d),
      .idx     (enc_idx),
      .one_hot (enc_one_hot)
   );

   // Next-state, remainder/count update and next-output decode
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      nnz_d    = nnz_q;
      load_bmp = bus.and_mode ? (bus.act_bmp & bus.wei_bmp) : bus.act_bmp;

      case (state_q)
         ST_IDLE: begin
            if (bus.bmp_valid) begin
               rem_d   = load_bmp;
               nnz_d   = '0;
               state_d = (load_bmp != '0) ? ST_SCAN : ST_DONE;
            end
         end
         ST_SCAN: begin
            if (bus.idx_ready) begin
               // Clear the emitted bit in place; positions stay absolute
               rem_d = rem_q & (rem_q - {{(DATA_WIDTH-1){1'b0}}, 1'b1});
               nnz_d = nnz_q + 1'b1;
               if (idx_last_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over any handshake in the same cycle
      if (bus.flush) begin
         state_d = ST_IDLE;
         rem_d   = '0;
         nnz_d   = '0;
      end

      bmp_ready_d = (state_d == ST_IDLE);
      idx_valid_d = (state_d == ST_SCAN);
      idx_d       = (state_d == ST_SCAN) ? enc_idx : '0;
      idx_last_d  = (state_d == ST_SCAN) ? enc_one_hot : 1'b0;
      row_done_d  = (state_d == ST_DONE);
      row_nnz_d   = (state_d == ST_DONE) ? nnz_d : '0;
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         nnz_q       <= '0;
         bmp_ready_q <= 1'b1;
         idx_valid_q <= 1'b0;
         idx_q       <= '0;
         idx_last_q  <= 1'b0;
         row_done_q  <= 1'b0;
         row_nnz_q   <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         nnz_q       <= nnz_d;
         bmp_ready_q <= bmp_ready_d;
         idx_valid_q <= idx_valid_d;
         idx_q       <= idx_d;
         idx_last_q  <= idx_last_d;
         row_done_q  <= row_done_d;
         row_nnz_q   <= row_nnz_d;
      end
   end

   assign bus.bmp_ready = bmp_ready_q;
   assign bus.idx_valid = idx_valid_q;
   assign bus.idx       = idx_q;
   assign bus.idx_last  = idx_last_q;
   assign bus.row_done  = row_done_q;
   assign bus.row_nnz   = row_nnz_q;

endmodule

// File: tb/tb_sparse_index_sched.sv
// tb/tb_sparse_index_sched.sv - self-checking bench for sparse_index_sched
module tb_sparse_index_sched;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   sparse_index_sched_if #(.DATA_WIDTH(16), .INDEX_WIDTH(4)) sif ();

   sparse_index_sched #(.DATA_WIDTH(16), .INDEX_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bmp_ready"}, 32'(sif.bmp_ready), 32'd1);
      chk({tag, "_idx_valid"}, 32'(sif.idx_valid), 32'd0);
      chk({tag, "_idx"},       32'(sif.idx),       32'd0);
      chk({tag, "_idx_last"},  32'(sif.idx_last),  32'd0);
      chk({tag, "_row_done"},  32'(sif.row_done),  32'd0);
      chk({tag, "_row_nnz"},   32'(sif.row_nnz),   32'd0);
   endtask

   // rmode: 0 = idx_ready always high, 1 = random, 2 = low for first 3 SCAN cycles
   task automatic run_row(input logic [15:0] a, input logic [15:0] w, input logic m, input int rmode);
      logic [15:0] eff;
      int          q[$];
      int          nnz;
      int          cyc;
      logic        rdy;
      eff = m ? (a & w) : a;
      for (int i = 0; i < 16; i++) begin
         if (eff[i]) q.push_back(i);
      end
      nnz = q.size();
      chk("accept_ready", 32'(sif.bmp_ready), 32'd1);
      sif.bmp_valid = 1'b1;
      sif.act_bmp   = a;
      sif.wei_bmp   = w;
      sif.and_mode  = m;
      sif.idx_ready = 1'($urandom_range(0, 1));
      tick();
      sif.bmp_valid = 1'b0;
      sif.act_bmp   = 16'($urandom);
      sif.wei_bmp   = 16'($urandom);
      sif.and_mode  = 1'($urandom_range(0, 1));
      cyc = 0;
      while (q.size() > 0) begin
         chk("scan_valid", 32'(sif.idx_valid), 32'd1);
         chk("scan_idx",   32'(sif.idx),       32'(q[0]));
         chk("scan_last",  32'(sif.idx_last),  32'(q.size() == 1));
         chk("scan_bmp_ready", 32'(sif.bmp_ready), 32'd0);
         chk("scan_row_done",  32'(sif.row_done),  32'd0);
         case (rmode)
            0:       rdy = 1'b1;
            2:       rdy = (cyc >= 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         sif.idx_ready = rdy;
         sif.bmp_valid = 1'($urandom_range(0, 1));
         tick();
         if (rdy) void'(q.pop_front());
         cyc++;
      end
      chk("done_pulse",     32'(sif.row_done),  32'd1);
      chk("done_nnz",       32'(sif.row_nnz),   32'(nnz));
      chk("done_idx_valid", 32'(sif.idx_valid), 32'd0);
      chk("done_bmp_ready", 32'(sif.bmp_ready), 32'd0);
      sif.bmp_valid = 1'b0;
      sif.idx_ready = 1'($urandom_range(0, 1));
      tick();
      chk("idle_bmp_ready", 32'(sif.bmp_ready), 32'd1);
      chk("idle_row_done",  32'(sif.row_done),  32'd0);
      chk("idle_row_nnz",   32'(sif.row_nnz),   32'd0);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rw;
      errors        = 0;
      checks        = 0;
      reset         = 1'b1;
      sif.flush     = 1'b0;
      sif.and_mode  = 1'b0;
      sif.bmp_valid = 1'b0;
      sif.act_bmp   = '0;
      sif.wei_bmp   = '0;
      sif.idx_ready = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");
      reset = 1'b0;
      tick();
      chk_reset_vals("post_reset_idle");

      run_row(16'h8421, 16'h0000, 1'b0, 0);
      run_row(16'h00FF, 16'h0F0F, 1'b1, 0);
      run_row(16'h00FF, 16'h0F0F, 1'b0, 0);
      run_row(16'h0000, 16'hFFFF, 1'b0, 0);
      run_row(16'h0006, 16'h0000, 1'b0, 2);
      run_row(16'hFFFF, 16'h0000, 1'b0, 0);
      run_row(16'hF0F0, 16'h0F0F, 1'b1, 1);

      // Flush after second index of 16'h00F0
      sif.bmp_valid = 1'b1;
      sif.act_bmp   = 16'h00F0;
      sif.and_mode  = 1'b0;
      sif.idx_ready = 1'b1;
      tick();
      sif.bmp_valid = 1'b0;
      chk("flush_idx0", 32'(sif.idx), 32'd4);
      tick();
      chk("flush_idx1", 32'(sif.idx), 32'd5);
      tick();
      chk("flush_pre_valid", 32'(sif.idx_valid), 32'd1);
      sif.flush = 1'b1;
      tick();
      sif.flush = 1'b0;
      chk("flush_bmp_ready", 32'(sif.bmp_ready), 32'd1);
      chk("flush_idx_valid", 32'(sif.idx_valid), 32'd0);
      chk("flush_row_done",  32'(sif.row_done),  32'd0);
      tick();
      chk("flush_no_done", 32'(sif.row_done), 32'd0);
      run_row(16'h0001, 16'h0000, 1'b0, 0);

      // Reset mid-SCAN
      sif.bmp_valid = 1'b1;
      sif.act_bmp   = 16'hFFFF;
      sif.idx_ready = 1'b1;
      tick();
      sif.bmp_valid = 1'b0;
      tick();
      tick();
      chk("midscan_valid", 32'(sif.idx_valid), 32'd1);
      reset = 1'b1;
      tick();
      chk_reset_vals("midscan_reset");
      reset = 1'b0;
      tick();
      run_row(16'h1234, 16'h0000, 1'b0, 1);

      // Randomized rows with varying density and back-pressure
      for (int n = 0; n < 30; n++) begin
         ra = 16'($urandom);
         rw = 16'($urandom);
         if (n % 3 == 0) ra = ra & 16'($urandom);
         run_row(ra, rw, 1'($urandom_range(0, 1)), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
